// File: rtl/data_mem_responder.sv
// Data-memory responder for the memory stage: one 16- or 32-bit request at a time,
// each 16-bit word transfer preceded by WAIT_CYC wait cycles, then a one-cycle ack.
module data_mem_responder #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic              i_en32,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata,
  output logic              o_ack,
  output logic              o_busy,
  output logic              o_stall
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWait   = 3'd1;
  localparam logic [2:0] StXferHi = 3'd2;
  localparam logic [2:0] StXferLo = 3'd3;
  localparam logic [2:0] StAck    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              en32_q, en32_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hi_done_q, hi_done_d;
  logic [15:0]       hi_q, hi_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [15:0]       mem_q [Depth];
  logic [ADDR_W-1:0] tgt;
  logic [15:0]       wr_half;
  logic              mem_we;
  logic [15:0]       rd_word;

  assign rd_word = mem_q[tgt];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    en32_d    = en32_q;
    wdata_d   = wdata_q;
    hi_done_d = hi_done_q;
    hi_d      = hi_q;
    rdata_d   = rdata_q;
    tgt       = addr_q;
    wr_half   = wdata_q[15:0];
    mem_we    = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_req) begin
          addr_d    = i_addr;
          we_d      = i_we;
          en32_d    = i_en32;
          wdata_d   = i_wdata;
          hi_done_d = 1'b0;
          if (WAIT_CYC > 0) begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end else begin
            state_d = i_en32 ? StXferHi : StXferLo;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = (en32_q && !hi_done_q) ? StXferHi : StXferLo;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StXferHi: begin
        wr_half   = wdata_q[31:16];
        mem_we    = we_q;
        hi_done_d = 1'b1;
        if (!we_q) hi_d = rd_word;
        if (WAIT_CYC > 0) begin
          state_d = StWait;
          cnt_d   = CntLoad;
        end else begin
          state_d = StXferLo;
        end
      end
      StXferLo: begin
        // Low half of a 32-bit access lives at the next word, wrapping at the top.
        tgt    = en32_q ? addr_q + ADDR_W'(1) : addr_q;
        mem_we = we_q;
        if (!we_q) rdata_d = en32_q ? {hi_q, rd_word} : {16'h0000, rd_word};
        state_d = StAck;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      en32_q    <= 1'b0;
      wdata_q   <= '0;
      hi_done_q <= 1'b0;
      hi_q      <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      en32_q    <= en32_d;
      wdata_q   <= wdata_d;
      hi_done_q <= hi_done_d;
      hi_q      <= hi_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage is never cleared; writes are gated by the state, which reset forces to idle.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[tgt] <= wr_half;
  end

  assign o_rdata = rdata_q;
  assign o_ack   = (state_q == StAck);
  assign o_busy  = (state_q == StWait) || (state_q == StXferHi) || (state_q == StXferLo);
  assign o_stall = i_req & ~o_ack;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_CYC=1 and WAIT_CYC=0), directed table,
// reset-abort sequence and randomized traffic against an array-based memory model.
module tb_data_mem_responder;

  localparam int unsigned AW = 11;
  localparam int WC[2] = '{0, 1};

  logic          clk;
  logic          rst;
  logic          req   [2];
  logic          we    [2];
  logic          en32  [2];
  logic [AW-1:0] addr  [2];
  logic [31:0]   wdata [2];
  logic [31:0]   rdata [2];
  logic          ack   [2];
  logic          busy  [2];
  logic          stall [2];

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.ADDR_W(AW), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .rst(rst), .i_req(req[0]), .i_we(we[0]), .i_en32(en32[0]),
    .i_addr(addr[0]), .i_wdata(wdata[0]), .o_rdata(rdata[0]), .o_ack(ack[0]),
    .o_busy(busy[0]), .o_stall(stall[0])
  );

  data_mem_responder #(.ADDR_W(AW), .WAIT_CYC(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_req(req[1]), .i_we(we[1]), .i_en32(en32[1]),
    .i_addr(addr[1]), .i_wdata(wdata[1]), .o_rdata(rdata[1]), .o_ack(ack[1]),
    .o_busy(busy[1]), .o_stall(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain word array per instance, plus which words are known.
  logic [15:0] mm    [2][2048];
  bit          kn    [2][2048];
  logic [31:0] lrd   [2];
  logic [31:0] lmask [2];

  typedef struct {
    int          d;
    bit          w;
    bit          e32;
    logic [10:0] a;
    logic [31:0] wd;
    bit          hold;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic mdl_read(input int d, input bit e32, input logic [10:0] a,
                          output logic [31:0] v, output logic [31:0] m);
    logic [10:0] a1;
    a1 = a + 11'd1;
    if (e32) begin
      v = {mm[d][a], mm[d][a1]};
      m = {kn[d][a] ? 16'hFFFF : 16'h0000, kn[d][a1] ? 16'hFFFF : 16'h0000};
    end else begin
      v = {16'h0000, mm[d][a]};
      m = {16'hFFFF, kn[d][a] ? 16'hFFFF : 16'h0000};
    end
  endtask

  task automatic mdl_apply(input int d, input bit w, input bit e32, input logic [10:0] a,
                           input logic [31:0] wd);
    logic [10:0] a1;
    a1 = a + 11'd1;
    if (w) begin
      if (e32) begin
        mm[d][a]  = wd[31:16]; kn[d][a]  = 1'b1;
        mm[d][a1] = wd[15:0];  kn[d][a1] = 1'b1;
      end else begin
        mm[d][a] = wd[15:0]; kn[d][a] = 1'b1;
      end
    end else begin
      mdl_read(d, e32, a, lrd[d], lmask[d]);
    end
  endtask

  // One request: present at a negedge, accepted at the next posedge, then follow to ack.
  // lat counts negedge samples after acceptance up to and including the ack cycle.
  task automatic access(input int d, input bit w, input bit e32, input logic [10:0] a,
                        input logic [31:0] wd, input bit hold, input bit drop,
                        output logic [31:0] rd, output int lat);
    bit done;
    bit dropped;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy[d]}, 32'd0);
    chk("ack_width", {31'd0, ack[d]}, 32'd0);
    we[d] = w; en32[d] = e32; addr[d] = a; wdata[d] = wd; req[d] = 1'b1;
    @(posedge clk);
    lat = 0; done = 0; dropped = 0; rd = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (ack[d]) begin
        done = 1;
        chk("ack_busy", {31'd0, busy[d]}, 32'd0);
        chk("ack_stall", {31'd0, stall[d]}, 32'd0);
        rd = rdata[d];
        if (!hold) req[d] = 1'b0;
      end else begin
        chk("run_busy", {31'd0, busy[d]}, 32'd1);
        chk("run_stall", {31'd0, stall[d]}, dropped ? 32'd0 : 32'd1);
        if (drop && !dropped) begin
          req[d] = 1'b0;
          dropped = 1;
        end
        // Inputs must be ignored while busy.
        addr[d] = 11'($urandom); wdata[d] = $urandom;
        we[d] = 1'($urandom); en32[d] = 1'($urandom);
      end
    end
    if (!done) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] rd, ev, em;
    int          lat;
    bit          w, e32, hold, drop;
    logic [10:0] a;
    logic [31:0] wd;

    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; en32[d] = 0; addr[d] = '0; wdata[d] = '0;
      lrd[d] = '0; lmask[d] = 32'hFFFF_FFFF;
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", {31'd0, ack[d]}, 32'd0);
      chk("rst_busy", {31'd0, busy[d]}, 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    //             d  w  e32 addr     wdata          hold exp_rd         lat
    tbl[0]  = '{1, 1, 0, 11'h010, 32'h0000_ABCD, 0, 32'h0000_0000, 3};
    tbl[1]  = '{1, 0, 0, 11'h010, 32'h0,         0, 32'h0000_ABCD, 3};
    tbl[2]  = '{1, 1, 1, 11'h020, 32'h1234_5678, 0, 32'h0000_ABCD, 5};
    tbl[3]  = '{1, 0, 0, 11'h020, 32'h0,         0, 32'h0000_1234, 3};
    tbl[4]  = '{1, 0, 0, 11'h021, 32'h0,         0, 32'h0000_5678, 3};
    tbl[5]  = '{1, 0, 1, 11'h020, 32'h0,         0, 32'h1234_5678, 5};
    tbl[6]  = '{1, 1, 1, 11'h7FF, 32'hDEAD_BEEF, 0, 32'h1234_5678, 5};
    tbl[7]  = '{1, 0, 0, 11'h7FF, 32'h0,         0, 32'h0000_DEAD, 3};
    tbl[8]  = '{1, 0, 0, 11'h000, 32'h0,         0, 32'h0000_BEEF, 3};
    tbl[9]  = '{1, 0, 1, 11'h7FF, 32'h0,         0, 32'hDEAD_BEEF, 5};
    tbl[10] = '{0, 1, 0, 11'h005, 32'h0000_2222, 0, 32'h0000_0000, 2};
    tbl[11] = '{0, 1, 1, 11'h006, 32'h3333_4444, 0, 32'h0000_0000, 3};
    tbl[12] = '{0, 0, 0, 11'h005, 32'h0,         1, 32'h0000_2222, 2};
    tbl[13] = '{0, 0, 0, 11'h006, 32'h0,         0, 32'h0000_3333, 2};
    tbl[14] = '{0, 0, 1, 11'h006, 32'h0,         0, 32'h3333_4444, 3};

    foreach (tbl[i]) begin
      access(tbl[i].d, tbl[i].w, tbl[i].e32, tbl[i].a, tbl[i].wd, tbl[i].hold, 1'b0, rd, lat);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      mdl_apply(tbl[i].d, tbl[i].w, tbl[i].e32, tbl[i].a, tbl[i].wd);
    end

    // Reset mid-access: high word written, low word untouched, no ack.
    access(1, 1'b1, 1'b1, 11'h030, 32'h0000_0000, 1'b0, 1'b0, rd, lat);
    mdl_apply(1, 1'b1, 1'b1, 11'h030, 32'h0000_0000);
    @(negedge clk);
    we[1] = 1; en32[1] = 1; addr[1] = 11'h030; wdata[1] = 32'hAAAA_5555; req[1] = 1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_hi", {31'd0, busy[1]}, 32'd1);
    @(negedge clk);
    rst = 1'b0; req[1] = 0;
    #1;
    chk("abort_ack", {31'd0, ack[1]}, 32'd0);
    chk("abort_busy", {31'd0, busy[1]}, 32'd0);
    chk("abort_rdata", rdata[1], 32'd0);
    chk("abort_rdata_other", rdata[0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      lrd[d] = '0; lmask[d] = 32'hFFFF_FFFF;
    end
    mm[1][11'h030] = 16'hAAAA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_ack", {31'd0, ack[1]}, 32'd0);
    end
    access(1, 1'b0, 1'b0, 11'h030, 32'h0, 1'b0, 1'b0, rd, lat);
    chk("abort_rd_hi", rd, 32'h0000_AAAA);
    access(1, 1'b0, 1'b0, 11'h031, 32'h0, 1'b0, 1'b0, rd, lat);
    chk("abort_rd_lo", rd, 32'h0000_0000);
    mdl_apply(1, 1'b0, 1'b0, 11'h031, 32'h0);

    // Random traffic near the wrap point, compared against the array model.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        w    = 1'($urandom);
        e32  = 1'($urandom);
        a    = 11'(11'h7F8 + 11'($urandom_range(0, 15)));
        wd   = $urandom;
        hold = ($urandom_range(0, 3) == 0);
        drop = ($urandom_range(0, 3) == 0);
        if (w) begin
          ev = lrd[d]; em = lmask[d];
        end else begin
          mdl_read(d, e32, a, ev, em);
        end
        access(d, w, e32, a, wd, hold, drop, rd, lat);
        chk("rand_lat", lat, (WC[d] + 1) * (e32 ? 2 : 1) + 1);
        if (em != 32'd0) chk("rand_rdata", rd & em, ev & em);
        mdl_apply(d, w, e32, a, wd);
      end
      req[d] = 1'b0;
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
